ram_word_loader: RTL and testbench
==================================

// Module: ram_word_loader
// PURPOSE
//  Upstream write-master for the 16-bit-word RAM (256 x 16, write sampled on posedge clk
//  when load=1). Takes a byte stream from the UART receiver, packs byte pairs (high byte
//  first) into 16-bit words and writes them to consecutive RAM addresses from a base
//  address. Keeps a running 16-bit checksum. Aborts on inter-byte timeout. Bootloads
//  programs and data before the CPU is released; busy steers the RAM port mux to this block.
// PARAMETERS
//  ADDR_W   8      RAM address width; the address wraps modulo 2**ADDR_W
//  TIMEOUT  50000  idle clk cycles allowed while waiting for a byte before abort (>=2)
// PORTS
//  clk          in   1         system clock, all state on posedge
//  rst_n        in   1         asynchronous reset, active low
//  start        in   1         1-cycle request to begin a load; ignored while busy=1
//  base         in   ADDR_W    first RAM address, sampled on accepted start
//  length       in   ADDR_W+1  word count 0..2**ADDR_W, sampled on accepted start
//  rx_data      in   8         received byte
//  rx_valid     in   1         1-cycle strobe: rx_data valid this cycle
//  ram_address  out  ADDR_W    RAM write address (registered)
//  ram_in       out  16        RAM write data (registered)
//  ram_load     out  1         RAM write enable, exactly 1 cycle per word
//  busy         out  1         1 from the cycle after an accepted start until completion or abort
//  done         out  1         1-cycle pulse: all length words written
//  error        out  1         sticky timeout flag; cleared by the next accepted start
//  checksum     out  16        sum mod 2**16 of words written since the last accepted start
//  words        out  ADDR_W+1  number of words written since the last accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; internal hi byte, pointer and timer 0.
//  States: IDLE, HI (wait high byte), LO (wait low byte), WR (write strobe).
//  IDLE: start=1 -> ptr<=base, remaining<=length, checksum<=0, words<=0, error<=0, timer<=0;
//   next HI, or when length=0: stay IDLE and pulse done next cycle with no write.
//   rx_valid in IDLE is discarded.
//  HI: rx_valid -> hi<=rx_data, timer<=0, next LO.
//  LO: rx_valid -> ram_in<={hi,rx_data}, ram_address<=ptr, timer<=0, next WR.
//  WR (1 cycle): ram_load=1, with ram_address/ram_in stable for the whole cycle; the
//   RAM captures the word on the closing edge. On that edge: ptr<=ptr+1 (wrap 2**ADDR_W-1 -> 0),
//   words+1, checksum<=checksum+word (carry discarded), remaining-1.
//   remaining reaches 0 -> IDLE, done=1 for the next cycle, busy=0 in that same cycle.
//   Otherwise -> HI; an rx_valid present during WR is captured as the next high byte
//   and the state advances directly to LO.
//  Latency: ram_load rises 1 cycle after the edge that samples the low byte.
//  Timeout: in HI and LO the timer increments each cycle without rx_valid; on reaching
//   TIMEOUT-1 -> error<=1, IDLE, busy<=0, no done pulse; a half-received word is dropped.
//   Words already written remain in RAM; checksum and words keep their values.
//  start while busy=1: ignored, no state change. ram_load is never 1 outside WR.
//  Reset asserted mid-load: immediate return to IDLE with outputs 0; any in-flight
//   write is abandoned (ram_load drops asynchronously).
//  ram_address and ram_in hold their last values when ram_load=0.
// TESTING
//  1 base=0,length=2, bytes 12 34 AB CD -> writes RAM[0]=1234, RAM[1]=ABCD, 2 load pulses,
//    done 1 cycle after the second WR, checksum=BE01, words=2.
//  2 base=FF,length=2, bytes 00 01 00 02 -> RAM[FF]=0001, RAM[00]=0002 (wrap), done.
//  3 length=0 -> done pulse the cycle after start, ram_load never 1, checksum=0.
//  4 TIMEOUT=8, length=2, bytes 11 22 33 then silence -> RAM[base]=1122 only, error=1
//    after 8 idle cycles, busy=0, no done; a new start clears error.
//  5 start pulsed mid-load and rx_valid in IDLE -> ignored; words=FFFF,FFFF sum=FFFE.
//  6 rst_n low between LO and WR -> ram_load stays 0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/ram_word_loader_if.sv
// Bundle between the byte-stream host, the 16-bit RAM write port and the word loader.
// master = the loader itself; slave = the host/RAM side that drives the request and the byte stream.
interface ram_word_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   length;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_address;
    logic [15:0]       ram_in;
    logic              ram_load;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;
    logic [ADDR_W:0]   words;

    modport master (
        input  start, base, length, rx_data, rx_valid,
        output ram_address, ram_in, ram_load, busy, done, error, checksum, words
    );

    modport slave (
        output start, base, length, rx_data, rx_valid,
        input  ram_address, ram_in, ram_load, busy, done, error, checksum, words
    );
endinterface

// File: rtl/ram_word_loader.sv
// Packs a UART byte stream (high byte first) into 16-bit words written to consecutive RAM
// addresses, with running checksum, word count and an inter-byte timeout abort.
module ram_word_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input logic                 clk,
    input logic                 rst_n,
    ram_word_loader_if.master   bus
);
    localparam int unsigned TimerW = $clog2(TIMEOUT);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] RemOne = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StHi, StLo, StWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [7:0]        hi_q, hi_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       sum_q, sum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        words_d = words_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ptr_d   = bus.base;
                    rem_d   = bus.length;
                    sum_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                    timer_d = '0;
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StHi;
                    end
                end
            end
            StHi, StLo: begin
                if (bus.rx_valid) begin
                    timer_d = '0;
                    if (state_q == StHi) begin
                        hi_d    = bus.rx_data;
                        state_d = StLo;
                    end else begin
                        data_d  = {hi_q, bus.rx_data};
                        addr_d  = ptr_q;
                        state_d = StWr;
                    end
                end else if (timer_q == TimerMax) begin
                    // Abort: a half-received word is dropped, counters keep their values.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWr: begin
                ptr_d   = ptr_q + 1'b1;
                words_d = words_q + 1'b1;
                sum_d   = sum_q + data_q;
                rem_d   = rem_q - 1'b1;
                timer_d = '0;
                if (rem_q == RemOne) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (bus.rx_valid) begin
                    // A byte arriving during the write strobe is the next high byte.
                    hi_d    = bus.rx_data;
                    state_d = StLo;
                end else begin
                    state_d = StHi;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Decoded from the state flop so reset drops the write strobe immediately.
    assign bus.ram_load    = (state_q == StWr);
    assign bus.busy        = (state_q != StIdle);
    assign bus.ram_address = addr_q;
    assign bus.ram_in      = data_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.checksum    = sum_q;
    assign bus.words       = words_q;
endmodule

// File: tb/tb_ram_word_loader.sv
// Directed bench for ram_word_loader: a queue-based write model plus literal checks of
// addresses, data, checksum, word count, done/error/busy and reset behaviour.
module tb_ram_word_loader;
    logic clk;
    logic rst_n;

    ram_word_loader_if #(.ADDR_W(8)) bus ();

    ram_word_loader #(
        .ADDR_W (8),
        .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  bq[$];
    logic [15:0] exp_sum;
    logic [8:0]  exp_words;
    int          exp_done;
    int          act_done;
    int          n_loads;
    int          n_checks;
    int          n_fail;
    logic [15:0] mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: what a load of bq from base with len words must write and report.
    task automatic model_load(input logic [7:0] b, input int len);
        exp_sum   = '0;
        exp_words = '0;
        for (int w = 0; w < len && 2 * w + 1 < bq.size(); w++) begin
            wr_t e;
            e.a = b + 8'(w);
            e.d = {bq[2 * w], bq[2 * w + 1]};
            exp_q.push_back(e);
            exp_sum   = exp_sum + e.d;
            exp_words = exp_words + 9'd1;
        end
        if (bq.size() / 2 >= len) exp_done++;
    endtask

    task automatic send_start(input logic [7:0] b, input logic [8:0] len);
        bus.start  = 1'b1;
        bus.base   = b;
        bus.length = len;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        bus.rx_data  = v;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bytes(input int gap);
        foreach (bq[i]) send_byte(bq[i], gap);
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy) ok = 1'b1;
        end
        check("wait_idle_bound", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic err);
        check({tag, "_words"}, 32'(bus.words), 32'(exp_words));
        check({tag, "_checksum"}, 32'(bus.checksum), 32'(exp_sum));
        check({tag, "_error"}, 32'(bus.error), 32'(err));
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_done_count"}, 32'(act_done), 32'(exp_done));
    endtask

    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end

    // Every write strobe must match the next modelled write, and only occur while busy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_load) begin
                n_loads++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.ram_address), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus.ram_address), 32'(e.a));
                    check("write_data", 32'(bus.ram_in), 32'(e.d));
                end
                check("load_while_busy", 32'(bus.busy), 32'd1);
            end
            if (bus.done) act_done++;
        end
    end

    initial begin
        int loads_before;
        n_checks     = 0;
        n_fail       = 0;
        exp_done     = 0;
        act_done     = 0;
        n_loads      = 0;
        exp_sum      = '0;
        exp_words    = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.length   = '0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;

        #12;
        check("rst_ram_load", 32'(bus.ram_load), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_outputs", {bus.ram_address, bus.ram_in, bus.checksum[7:0]}, 32'd0);
        check("rst_words", 32'(bus.words), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: two words from address 0
        bq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        model_load(8'h00, 2);
        send_start(8'h00, 9'd2);
        drive_bytes(0);
        @(negedge clk);
        check("t1_load_latency", 32'(bus.ram_load), 32'd1);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done), 32'd1);
        check("t1_busy_low_with_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(bus.done), 32'd0);
        check("t1_checksum_lit", 32'(bus.checksum), 32'h0000_BE01);
        check("t1_addr_hold", 32'(bus.ram_address), 32'h01);
        check("t1_data_hold", 32'(bus.ram_in), 32'hABCD);
        check("t1_ram0", 32'(mem[0]), 32'h1234);
        check("t1_ram1", 32'(mem[1]), 32'hABCD);
        check("t1_loads_lit", 32'(n_loads), 32'd2);
        check_status("t1", 1'b0);

        // 2: address wrap, gaps between bytes
        bq = '{8'h00, 8'h01, 8'h00, 8'h02};
        model_load(8'hFF, 2);
        send_start(8'hFF, 9'd2);
        drive_bytes(2);
        wait_idle(20);
        check("t2_ramFF", 32'(mem[8'hFF]), 32'h0001);
        check("t2_ram00", 32'(mem[8'h00]), 32'h0002);
        check_status("t2", 1'b0);

        // 4: timeout after a word and a half
        bq = '{8'h11, 8'h22, 8'h33};
        model_load(8'h20, 2);
        send_start(8'h20, 9'd2);
        drive_bytes(0);
        repeat (8) @(negedge clk);
        check("t4_busy_before_timeout", 32'(bus.busy), 32'd1);
        check("t4_error_before_timeout", 32'(bus.error), 32'd0);
        @(negedge clk);
        check("t4_error_set", 32'(bus.error), 32'd1);
        check("t4_no_done", 32'(bus.done), 32'd0);
        check("t4_ram20", 32'(mem[8'h20]), 32'h1122);
        check("t4_words_lit", 32'(bus.words), 32'd1);
        check_status("t4", 1'b1);

        // 3: zero-length load, also clears the sticky error
        bq.delete();
        model_load(8'h30, 0);
        loads_before = n_loads;
        send_start(8'h30, 9'd0);
        @(negedge clk);
        check("t3_done_next_cycle", 32'(bus.done), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_error_cleared", 32'(bus.error), 32'd0);
        @(negedge clk);
        check("t3_no_load", 32'(n_loads - loads_before), 32'd0);
        check_status("t3", 1'b0);

        // 5: rx_valid in idle discarded, start mid-load ignored
        send_byte(8'hAA, 1);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(8'h10, 2);
        send_start(8'h10, 9'd2);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_start(8'h50, 9'd7);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 0);
        wait_idle(20);
        check("t5_sum_lit", 32'(bus.checksum), 32'h0000_FFFE);
        check_status("t5", 1'b0);

        // Longer run with random bytes, length 5 from 0x40
        bq.delete();
        for (int i = 0; i < 10; i++) bq.push_back(8'($urandom_range(0, 255)));
        model_load(8'h40, 5);
        send_start(8'h40, 9'd5);
        drive_bytes(1);
        wait_idle(30);
        check_status("rand", 1'b0);

        // 6: reset while the write strobe is up
        loads_before = n_loads;
        send_start(8'h80, 9'd2);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        rst_n = 1'b0;
        #1;
        check("t6_ram_load_async", 32'(bus.ram_load), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_outputs", {bus.ram_address, bus.ram_in, bus.checksum[7:0]}, 32'd0);
        check("t6_words", 32'(bus.words), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_still_idle", 32'(bus.busy), 32'd0);
        check("t6_no_write", 32'(n_loads - loads_before), 32'd0);
        check("t6_done_count", 32'(act_done), 32'(exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
